// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The arbiter takes the slave view; whoever drives requests takes the master view.
interface decoder_rr_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt_n;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output en, req, done,
        input  gnt_n, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt_n, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for one 8-way decoder-selected resource.
// Grants are active-low one-hot selects (index k pulls bit k low), separated by
// GAP_CYCLES all-high cycles, and forcibly revoked after MAX_HOLD cycles.
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_rr_arbiter_if.slave  bus
);

    localparam int unsigned HOLD_W = (MAX_HOLD == 32'd0) ? 1 : $clog2(MAX_HOLD + 32'd1);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 32'd1);

    // Last hold count value before a forced revoke; unused when MAX_HOLD is 0.
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 32'd0) ? '0 : HOLD_W'(MAX_HOLD - 32'd1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Active-low 3-to-8 decode, same mapping as the resource's select decoder.
    function automatic logic [7:0] decode_n(input logic [2:0] idx);
        return ~(8'd1 << idx);
    endfunction

    // Round-robin pick: first set request scanning upward from last+1, wrapping mod 8.
    // Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [2:0] last, input logic [7:0] req);
        logic       found;
        logic [2:0] idx;
        logic [2:0] cand;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            cand = last + 3'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
                idx   = idx;
            end
        end
        return {found, idx};
    endfunction

    state_e              state_q, state_d;
    logic [2:0]          last_q, last_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [7:0]          gnt_n_q, gnt_n_d;
    logic [2:0]          gnt_idx_q, gnt_idx_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic                timeout_q, timeout_d;

    logic [3:0]          pick_s;
    logic                win_found_s;
    logic [2:0]          win_idx_s;
    logic                grant_ok_s;
    logic                timed_out_s;
    logic                other_exit_s;
    logic                release_s;
    logic                gap_last_s;

    assign pick_s       = rr_pick(last_q, bus.req);
    assign win_found_s  = pick_s[3];
    assign win_idx_s    = pick_s[2:0];
    assign grant_ok_s   = bus.en && win_found_s;
    assign timed_out_s  = (MAX_HOLD != 32'd0) && (hold_cnt_q == HOLD_LAST);
    assign other_exit_s = bus.done || !bus.req[gnt_idx_q] || !bus.en;
    assign release_s    = timed_out_s || other_exit_s;
    assign gap_last_s   = (gap_cnt_q == GAP_LAST);

    // State and registered outputs; reset drops any select immediately with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 3'd7;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            gnt_n_q     <= 8'hFF;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            gnt_n_q     <= gnt_n_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state selection for the IDLE / GRANT / GAP sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok_s) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_GAP: begin
                if (gap_last_s) begin
                    state_d = grant_ok_s ? ST_GRANT : ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the select lines, counters, pointer and timeout pulse.
    always_comb begin
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        gnt_n_d     = gnt_n_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok_s) begin
                    gnt_n_d     = decode_n(win_idx_s);
                    gnt_idx_d   = win_idx_s;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end else begin
                    gnt_n_d     = 8'hFF;
                    gnt_valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    // Pointer moves only on release, so the holder drops to lowest priority.
                    gnt_n_d     = 8'hFF;
                    gnt_valid_d = 1'b0;
                    last_d      = gnt_idx_q;
                    gap_cnt_d   = '0;
                    timeout_d   = timed_out_s && !other_exit_s;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
                end else begin
                    hold_cnt_d  = hold_cnt_q;
                end
            end
            ST_GAP: begin
                if (gap_last_s && grant_ok_s) begin
                    gnt_n_d     = decode_n(win_idx_s);
                    gnt_idx_d   = win_idx_s;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end else if (gap_last_s) begin
                    gnt_n_d     = 8'hFF;
                    gnt_valid_d = 1'b0;
                end else begin
                    gap_cnt_d   = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                gnt_n_d     = 8'hFF;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.gnt_n     = gnt_n_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: hand-derived vector table, a rotation sequence,
// then randomized traffic compared against a cycle-level behavioural model.
module tb_decoder_rr_arbiter;

    localparam int MAXH = 4;
    localparam int GAPC = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    decoder_rr_arbiter_if bus_if ();

    decoder_rr_arbiter #(
        .MAX_HOLD   (MAXH),
        .GAP_CYCLES (GAPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt_n;
        logic [2:0] idx;
        logic       valid;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state: who holds the resource and for how long.
    bit m_granted;
    int m_idx;
    int m_last;
    int m_held;
    int m_gap;
    bit m_tmo;

    function automatic vec_t mk(logic r, logic e, logic [7:0] q, logic d,
                                logic [7:0] g, logic [2:0] x, logic v, logic t);
        vec_t s;
        s.rst = r; s.en = e; s.req = q; s.done = d;
        s.gnt_n = g; s.idx = x; s.valid = v; s.tmo = t;
        return s;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_try_grant();
        bit found;
        int c;
        found = 1'b0;
        if (bus_if.en) begin
            for (int s = 1; s <= 8; s++) begin
                c = (m_last + s) % 8;
                if (!found && bus_if.req[c]) begin
                    found = 1'b1;
                    m_granted = 1'b1;
                    m_idx = c;
                    m_held = 1;
                end
            end
        end
    endtask

    task automatic model_step();
        bit up;
        bit other;
        if (rst) begin
            m_granted = 1'b0; m_idx = 0; m_last = 7; m_held = 0; m_gap = 0; m_tmo = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (m_granted) begin
                up    = (MAXH != 0) && (m_held == MAXH);
                other = bus_if.done || !bus_if.req[m_idx] || !bus_if.en;
                if (up || other) begin
                    m_granted = 1'b0;
                    m_last = m_idx;
                    m_gap = GAPC;
                    m_tmo = up && !other;
                end else begin
                    m_held++;
                end
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) model_try_grant();
            end else begin
                model_try_grant();
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input int cyc);
        logic [7:0] exp_n;
        logic [2:0] exp_idx;
        exp_idx = 3'(m_idx);
        exp_n = m_granted ? ~(8'd1 << exp_idx) : 8'hFF;
        chk($sformatf("rnd%0d gnt_n", cyc), bus_if.gnt_n, exp_n);
        chk($sformatf("rnd%0d gnt_idx", cyc), {5'd0, bus_if.gnt_idx}, {5'd0, exp_idx});
        chk($sformatf("rnd%0d gnt_valid", cyc), {7'd0, bus_if.gnt_valid}, {7'd0, m_granted});
        chk($sformatf("rnd%0d timeout", cyc), {7'd0, bus_if.timeout}, {7'd0, m_tmo});
    endtask

    initial begin
        logic [2:0] k3;

        bus_if.en = 1'b1; bus_if.req = 8'h00; bus_if.done = 1'b0;

        // rst en req done | gnt_n idx valid tmo
        vecs.push_back(mk(1'b1, 1'b1, 8'h00, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h00, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h08, 1'b0, 8'hF7, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h08, 1'b1, 8'hFF, 3'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h08, 1'b0, 8'hF7, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 3'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 3'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h00, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h21, 1'b0, 8'hFE, 3'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h21, 1'b0, 8'hFE, 3'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h21, 1'b0, 8'hFE, 3'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h21, 1'b0, 8'hFE, 3'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h21, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 8'h21, 1'b0, 8'hDF, 3'd5, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h04, 1'b0, 8'hFF, 3'd5, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h04, 1'b0, 8'hFB, 3'd2, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h04, 1'b0, 8'hFF, 3'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h04, 1'b0, 8'hFF, 3'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h04, 1'b0, 8'hFF, 3'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h04, 1'b0, 8'hFB, 3'd2, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h04, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h81, 1'b0, 8'hFE, 3'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h81, 1'b0, 8'hFE, 3'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h81, 1'b0, 8'hFE, 3'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h81, 1'b0, 8'hFE, 3'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h81, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h81, 1'b0, 8'h7F, 3'd7, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h81, 1'b1, 8'hFF, 3'd7, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h81, 1'b0, 8'hFE, 3'd0, 1'b1, 1'b0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            bus_if.en = vecs[i].en;
            bus_if.req = vecs[i].req;
            bus_if.done = vecs[i].done;
            tick();
            chk($sformatf("row%0d gnt_n", i), bus_if.gnt_n, vecs[i].gnt_n);
            chk($sformatf("row%0d gnt_idx", i), {5'd0, bus_if.gnt_idx}, {5'd0, vecs[i].idx});
            chk($sformatf("row%0d gnt_valid", i), {7'd0, bus_if.gnt_valid}, {7'd0, vecs[i].valid});
            chk($sformatf("row%0d timeout", i), {7'd0, bus_if.timeout}, {7'd0, vecs[i].tmo});
        end

        // Rotation: all requesting, done on every grant -> 0,1,...,7,0 with one gap each.
        rst = 1'b1; bus_if.en = 1'b1; bus_if.req = 8'h00; bus_if.done = 1'b0;
        tick();
        chk("rot reset", bus_if.gnt_n, 8'hFF);
        rst = 1'b0; bus_if.req = 8'hFF;
        tick();
        chk("rot first", bus_if.gnt_n, 8'hFE);
        for (int k = 1; k <= 8; k++) begin
            bus_if.done = 1'b1;
            tick();
            chk($sformatf("rot gap%0d", k), bus_if.gnt_n, 8'hFF);
            chk($sformatf("rot gapvalid%0d", k), {7'd0, bus_if.gnt_valid}, 8'd0);
            bus_if.done = 1'b0;
            tick();
            k3 = 3'(k % 8);
            chk($sformatf("rot grant%0d", k), bus_if.gnt_n, ~(8'd1 << k3));
            chk($sformatf("rot idx%0d", k), {5'd0, bus_if.gnt_idx}, {5'd0, k3});
        end

        // Randomized traffic against the behavioural model.
        rst = 1'b1; bus_if.done = 1'b0;
        tick();
        chk_model(-1);
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus_if.en = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 7))
                0, 1:    bus_if.req = 8'($urandom);
                2:       bus_if.req = 8'd1 << $urandom_range(0, 7);
                3:       bus_if.req = 8'h00;
                default: bus_if.req = bus_if.req;
            endcase
            bus_if.done = ($urandom_range(0, 7) == 0);
            tick();
            chk_model(c);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
